regfile_dump_reader: RTL

- Debug and scan engine that reads a contiguous range of the 32x64 register file through a read port (RA/BusA pair).
- Streams each register value out with its index over a valid/ready handshake.
- Sits beside the datapath and shares a read port via the datapath's port mux.
- Asserts Freeze while active so the datapath stalls register writes, giving a coherent snapshot.

---
 rtl/regfile_dump_reader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Debug/scan engine that walks a contiguous, inclusive index range of the
// register file through one borrowed read port (RA -> BusA) and streams each
// register value, tagged with its index, over a valid/ready handshake.
// While active it raises Freeze so the datapath holds off register writes and
// the dumped range is a coherent snapshot.
//
// Ports
//   Clk        in   clock, all state changes on posedge
//   Reset_n    in   asynchronous active-low reset
//   Start      in   single-cycle dump request, sampled only when idle
//   StartIdx   in   first register index, latched on accepted Start
//   EndIdx     in   last register index (inclusive), latched on accepted Start
//   Abort      in   synchronous cancel of an active dump
//   RA         out  read address to the register-file read port
//   BusA       in   read data, combinational from RA (needs a settle cycle)
//   DumpValid  out  DumpData/DumpIdx carry a valid beat
//   DumpReady  in   consumer accepts the beat
//   DumpData   out  captured register value
//   DumpIdx    out  index of the captured register
//   Busy       out  high from accepted Start until back in idle
//   Freeze     out  copy of Busy; datapath must keep RegWr low while high
//   Done       out  one-cycle pulse on normal completion or range error
//   Err        out  qualifies Done; 1 = StartIdx > EndIdx, no beats sent
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] StartIdx,
    input  logic [ADDR_WIDTH-1:0] EndIdx,
    input  logic                  Abort,
    output logic [ADDR_WIDTH-1:0] RA,
    input  logic [DATA_WIDTH-1:0] BusA,
    output logic                  DumpValid,
    input  logic                  DumpReady,
    output logic [DATA_WIDTH-1:0] DumpData,
    output logic [ADDR_WIDTH-1:0] DumpIdx,
    output logic                  Busy,
    output logic                  Freeze,
    output logic                  Done,
    output logic                  Err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_SEND   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [ADDR_WIDTH-1:0] r_ra;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_range_err;
    logic                  w_xfer;
    logic                  w_at_last;
    logic [ADDR_WIDTH-1:0] w_cur_inc;

    assign w_range_err = (StartIdx > EndIdx);
    assign w_xfer      = r_valid && DumpReady;
    // Compared before the increment so a range ending at the top index
    // finishes instead of wrapping the index back to 0.
    assign w_at_last   = (r_cur == r_last);
    assign w_cur_inc   = r_cur + ADDR_WIDTH'(1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_last  <= '0;
            r_ra    <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (Start) begin
                        r_cur  <= StartIdx;
                        r_last <= EndIdx;
                        r_busy <= 1'b1;
                        if (w_range_err) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_ra    <= StartIdx;
                            r_state <= S_SETUP;
                        end
                    end
                end

                // RA has been stable for this whole cycle, so BusA is settled
                // by the closing edge and can be captured.
                S_SETUP: begin
                    if (Abort) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_data  <= BusA;
                        r_idx   <= r_cur;
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end
                end

                // Abort wins over a coincident handshake: the beat is dropped.
                S_SEND: begin
                    if (Abort) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_xfer) begin
                        r_valid <= 1'b0;
                        if (w_at_last) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                        end else begin
                            r_cur   <= w_cur_inc;
                            r_ra    <= w_cur_inc;
                            r_state <= S_SETUP;
                        end
                    end
                end

                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RA        = r_ra;
    assign DumpValid = r_valid;
    assign DumpData  = r_data;
    assign DumpIdx   = r_idx;
    assign Busy      = r_busy;
    assign Freeze    = r_busy;
    assign Done      = r_done;
    assign Err       = r_err;

endmodule
